ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pipe_reg.sv | 22 ++
 rtl/ex_mem_reg.sv | 130 +++++++++++++
 tb/tb_ex_mem_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: zero-register index and EX/MEM control bundle.
package cpu_pkg;

    localparam int unsigned XZR_W  = 5;
    localparam logic [XZR_W-1:0] XZR = 5'd31;
    localparam int unsigned CNT_W  = 32;

    typedef struct packed {
        logic valid;
        logic MemWrite;
        logic mem_read;
        logic memToReg;
        logic RegWrite;
    } exmem_ctrl_t;

    localparam int unsigned CTRL_W = $bits(exmem_ctrl_t);

    // Gate side-effecting controls with the slot valid so a dead slot never stores, loads or writes back.
    function automatic exmem_ctrl_t qualify_ctrl(input exmem_ctrl_t c);
        exmem_ctrl_t q;
        q          = c;
        q.MemWrite = c.MemWrite & c.valid;
        q.mem_read = c.mem_read & c.valid;
        q.RegWrite = c.RegWrite & c.valid;
        return q;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous reset to RST_VAL, load when en is high.
module pipe_reg #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: reset wins, otherwise load on enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush control, forwarding and load-use decode.
// Optional build macro EX_MEM_PERF_CNT_EN adds ld_count/st_count performance counters.
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_MemWrite,
    input  logic              ex_mem_read,
    input  logic              ex_memToReg,
    input  logic              ex_RegWrite,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_Rd,
    input  logic [REG_W-1:0]  id_Rn,
    input  logic [REG_W-1:0]  id_Rm,
    output logic              MemWrite,
    output logic              mem_read,
    output logic              memToReg,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] dataMem_in,
    output logic              mem_valid,
    output logic              mem_RegWrite,
    output logic [REG_W-1:0]  mem_Rd,
    output logic              fwd_en,
    output logic              load_use
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  ld_count,
    output logic [CNT_W-1:0]  st_count
`endif
);

    exmem_ctrl_t ex_ctrl;
    exmem_ctrl_t ctrl_d;
    exmem_ctrl_t ctrl_q;
    logic        ctrl_en;
    logic        data_en;
    logic        not_xzr;

    // Control fields: a flush loads a bubble even under stall; otherwise stall holds.
    always_comb begin
        ex_ctrl          = '0;
        ex_ctrl.valid    = ex_valid;
        ex_ctrl.MemWrite = ex_MemWrite;
        ex_ctrl.mem_read = ex_mem_read;
        ex_ctrl.memToReg = ex_memToReg;
        ex_ctrl.RegWrite = ex_RegWrite;
        ctrl_d           = flush ? exmem_ctrl_t'('0) : qualify_ctrl(ex_ctrl);
        ctrl_en          = flush | ~stall;
        data_en          = ~stall & ~flush;
    end

    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_en),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    // Data fields are held through a flush; only a real capture replaces them.
    pipe_reg #(.WIDTH(DATA_W)) u_addr (
        .clk   (clk),
        .reset (reset),
        .en    (data_en),
        .d     (ex_alu_result),
        .q     (mem_addr)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_store (
        .clk   (clk),
        .reset (reset),
        .en    (data_en),
        .d     (ex_store_data),
        .q     (dataMem_in)
    );

    pipe_reg #(.WIDTH(REG_W)) u_rd (
        .clk   (clk),
        .reset (reset),
        .en    (data_en),
        .d     (ex_Rd),
        .q     (mem_Rd)
    );

    assign mem_valid    = ctrl_q.valid;
    assign MemWrite     = ctrl_q.MemWrite;
    assign mem_read     = ctrl_q.mem_read;
    assign memToReg     = ctrl_q.memToReg;
    assign mem_RegWrite = ctrl_q.RegWrite;

    // Hazard decode from the held MEM slot; XZR is never a real producer.
    always_comb begin
        not_xzr  = (mem_Rd != REG_W'(XZR));
        fwd_en   = mem_valid & mem_RegWrite & ~memToReg & not_xzr;
        load_use = mem_valid & mem_read & not_xzr &
                   ((mem_Rd == id_Rn) | (mem_Rd == id_Rm));
    end

`ifdef EX_MEM_PERF_CNT_EN
    logic ld_hit;
    logic st_hit;

    assign ld_hit = data_en & ex_valid & ex_mem_read;
    assign st_hit = data_en & ex_valid & ex_MemWrite;

    // Count captured valid loads and stores; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_count <= '0;
            st_count <= '0;
        end else begin
            if (ld_hit) begin
                ld_count <= ld_count + CNT_W'(1);
            end
            if (st_hit) begin
                st_count <= st_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: driver pushes hand-computed expectations, monitor pops and compares.
module tb_ex_mem_reg;

    logic        clk;
    logic        reset, stall, flush;
    logic        ex_valid, ex_MemWrite, ex_mem_read, ex_memToReg, ex_RegWrite;
    logic [63:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_Rd, id_Rn, id_Rm;
    logic        MemWrite, mem_read, memToReg, mem_valid, mem_RegWrite;
    logic [63:0] mem_addr, dataMem_in;
    logic [4:0]  mem_Rd;
    logic        fwd_en, load_use;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] ld_count, st_count;
`endif

    ex_mem_reg #(.DATA_W(64), .REG_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_MemWrite   (ex_MemWrite),
        .ex_mem_read   (ex_mem_read),
        .ex_memToReg   (ex_memToReg),
        .ex_RegWrite   (ex_RegWrite),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_Rd         (ex_Rd),
        .id_Rn         (id_Rn),
        .id_Rm         (id_Rm),
        .MemWrite      (MemWrite),
        .mem_read      (mem_read),
        .memToReg      (memToReg),
        .mem_addr      (mem_addr),
        .dataMem_in    (dataMem_in),
        .mem_valid     (mem_valid),
        .mem_RegWrite  (mem_RegWrite),
        .mem_Rd        (mem_Rd),
        .fwd_en        (fwd_en),
        .load_use      (load_use)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .ld_count      (ld_count),
        .st_count      (st_count)
`endif
    );

    typedef struct {
        int          id;
        logic        v, mw, mr, m2r, rw;
        logic [63:0] addr, din;
        logic [4:0]  rd;
        logic        fwd, lu;
        logic [31:0] ldc, stc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, name, act, req);
        end
    endtask

    // Monitor: after every rising edge, check the DUT against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mem_valid",    e.id, 64'(mem_valid),    64'(e.v));
                chk("MemWrite",     e.id, 64'(MemWrite),     64'(e.mw));
                chk("mem_read",     e.id, 64'(mem_read),     64'(e.mr));
                chk("memToReg",     e.id, 64'(memToReg),     64'(e.m2r));
                chk("mem_RegWrite", e.id, 64'(mem_RegWrite), 64'(e.rw));
                chk("mem_addr",     e.id, mem_addr,          e.addr);
                chk("dataMem_in",   e.id, dataMem_in,        e.din);
                chk("mem_Rd",       e.id, 64'(mem_Rd),       64'(e.rd));
                chk("fwd_en",       e.id, 64'(fwd_en),       64'(e.fwd));
                chk("load_use",     e.id, 64'(load_use),     64'(e.lu));
`ifdef EX_MEM_PERF_CNT_EN
                chk("ld_count",     e.id, 64'(ld_count),     64'(e.ldc));
                chk("st_count",     e.id, 64'(st_count),     64'(e.stc));
`endif
            end
        end
    end

    task automatic apply(input logic rst, st, fl, v, mw, mr, m2r, rw,
                         input logic [63:0] alu, sd,
                         input logic [4:0] rd, rn, rm);
        reset         = rst;
        stall         = st;
        flush         = fl;
        ex_valid      = v;
        ex_MemWrite   = mw;
        ex_mem_read   = mr;
        ex_memToReg   = m2r;
        ex_RegWrite   = rw;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_Rd         = rd;
        id_Rn         = rn;
        id_Rm         = rm;
    endtask

    // Queue the expectation for the edge following the current inputs, then advance a cycle.
    task automatic expect_o(input logic v, mw, mr, m2r, rw,
                            input logic [63:0] addr, din,
                            input logic [4:0] rd,
                            input logic fwd, lu,
                            input logic [31:0] ldc, stc);
        exp_t e;
        e.id = vec_id; e.v = v; e.mw = mw; e.mr = mr; e.m2r = m2r; e.rw = rw;
        e.addr = addr; e.din = din; e.rd = rd; e.fwd = fwd; e.lu = lu;
        e.ldc = ldc; e.stc = stc;
        q.push_back(e);
        vec_id++;
        @(negedge clk);
    endtask

    initial begin
        apply(1,0,0, 0,0,0,0,0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);

        // Reset state
        apply(1,0,0, 0,0,0,0,0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);
        expect_o(0,0,0,0,0, 64'h0, 64'h0, 5'd0, 0,0, 0,0);
        // Valid store
        apply(0,0,0, 1,1,0,0,0, 64'h100, 64'hDEAD, 5'd5, 5'd0, 5'd0);
        expect_o(1,1,0,0,0, 64'h100, 64'hDEAD, 5'd5, 0,0, 0,1);
        // Three stalled cycles with changing inputs hold everything
        for (int i = 0; i < 3; i++) begin
            apply(0,1,0, 1,0,1,1,1, 64'h200 + 64'(i), 64'h300 + 64'(i), 5'd7, 5'd5, 5'd5);
            expect_o(1,1,0,0,0, 64'h100, 64'hDEAD, 5'd5, 0,0, 0,1);
        end
        // Flush beats stall: bubble, data held
        apply(0,1,1, 1,1,0,0,0, 64'h999, 64'h888, 5'd9, 5'd0, 5'd0);
        expect_o(0,0,0,0,0, 64'h100, 64'hDEAD, 5'd5, 0,0, 0,1);
        // Valid load to x3, ID reads x3 -> load-use
        apply(0,0,0, 1,0,1,1,1, 64'h40, 64'h0, 5'd3, 5'd0, 5'd3);
        expect_o(1,0,1,1,1, 64'h40, 64'h0, 5'd3, 0,1, 1,1);
        // Load to XZR never flags load-use
        apply(0,0,0, 1,0,1,1,1, 64'h48, 64'h0, 5'd31, 5'd31, 5'd31);
        expect_o(1,0,1,1,1, 64'h48, 64'h0, 5'd31, 0,0, 2,1);
        // Invalid slot with controls set -> no store/load/write-back
        apply(0,0,0, 0,1,1,0,1, 64'h55, 64'h66, 5'd2, 5'd2, 5'd2);
        expect_o(0,0,0,0,0, 64'h55, 64'h66, 5'd2, 0,0, 2,1);
        // ALU result with full-width pattern, forwardable
        apply(0,0,0, 1,0,0,0,1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 5'd4, 5'd0);
        expect_o(1,0,0,0,1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 1,0, 2,1);
        // ALU write to XZR is not forwarded
        apply(0,0,0, 1,0,0,0,1, 64'h10, 64'h20, 5'd31, 5'd31, 5'd0);
        expect_o(1,0,0,0,1, 64'h10, 64'h20, 5'd31, 0,0, 2,1);
        // Second store
        apply(0,0,0, 1,1,0,0,0, 64'h300, 64'hBEEF, 5'd0, 5'd0, 5'd0);
        expect_o(1,1,0,0,0, 64'h300, 64'hBEEF, 5'd0, 0,0, 2,2);
        // Reset while the store is held under stall
        apply(1,1,0, 1,1,0,0,0, 64'h300, 64'hBEEF, 5'd0, 5'd0, 5'd0);
        expect_o(0,0,0,0,0, 64'h0, 64'h0, 5'd0, 0,0, 0,0);
        // Two valid loads after reset
        apply(0,0,0, 1,0,1,1,1, 64'h80, 64'h0, 5'd9, 5'd9, 5'd0);
        expect_o(1,0,1,1,1, 64'h80, 64'h0, 5'd9, 0,1, 1,0);
        apply(0,0,0, 1,0,1,1,1, 64'h88, 64'h0, 5'd10, 5'd9, 5'd0);
        expect_o(1,0,1,1,1, 64'h88, 64'h0, 5'd10, 0,0, 2,0);
        // Flush alone with a valid load presented: bubble, data held, not counted
        apply(0,0,1, 1,0,1,1,1, 64'hAA, 64'hBB, 5'd12, 5'd10, 5'd10);
        expect_o(0,0,0,0,0, 64'h88, 64'h0, 5'd10, 0,0, 2,0);
        // Idle capture
        apply(0,0,0, 0,0,0,0,0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);
        expect_o(0,0,0,0,0, 64'h0, 64'h0, 5'd0, 0,0, 2,0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
